// File: rtl/mem_reader.sv
// mem_reader: read-side controller for the A/B vector memories.
// On start it issues DEPTH sequential reads to both memories. The memories
// have a 1-cycle registered read latency. The returned (a, b) pairs go out
// as a valid/ready stream carrying an element index and a last flag.
// A 2-entry output FIFO holds in-flight data while the stream is stalled.
// Reads are issued only when the FIFO has room for every read still
// outstanding, so backpressure never drops a beat.

module mem_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int VETOR_WIDTH = 4,
  parameter int DEPTH       = VETOR_WIDTH * DATA_WIDTH,
  parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout_a,
  input  logic [DATA_WIDTH-1:0] mem_dout_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_last
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // The issue counter needs one extra bit so that it can hold DEPTH itself.
  localparam int CNT_W   = ADDR_WIDTH + 1;
  localparam int ENTRY_W = 2 * DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [CNT_W-1:0]        issued_r;
  logic                    inflight_r;
  logic [ADDR_WIDTH-1:0]   inflight_idx_r;
  logic                    done_r;
  // FIFO entry layout, from MSB to LSB: {a, b, idx, last}.
  logic [ENTRY_W-1:0]      head_r;
  logic [ENTRY_W-1:0]      tail_r;
  logic [1:0]              count_r;

  logic                    pop_s;
  logic                    push_s;
  logic                    rd_en_s;
  logic                    start_acc_s;
  logic                    finish_s;
  logic [2:0]              occupancy_s;
  logic [ENTRY_W-1:0]      push_entry_s;

  // Handshake decode and issue gating. FIFO entries plus the read in flight,
  // less the beat leaving this cycle, must stay below the FIFO depth.
  always_comb begin
    pop_s        = (count_r != 2'd0) & out_ready;
    push_s       = inflight_r;
    occupancy_s  = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    rd_en_s      = (state_r == ST_RUN) && (issued_r < DEPTH_C) && (occupancy_s < 3'd2);
    start_acc_s  = (state_r == ST_IDLE) && start;
    finish_s     = (state_r == ST_RUN) && pop_s && head_r[0];
    push_entry_s = {mem_dout_a, mem_dout_b, inflight_idx_r, (inflight_idx_r == LAST_IDX)};
  end

  // Next-state logic: run from an accepted start until the last beat leaves.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (finish_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Issue counter: cleared when a sequence starts, incremented per read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued_r <= {CNT_W{1'b0}};
    end else if (start_acc_s) begin
      issued_r <= {CNT_W{1'b0}};
    end else if (rd_en_s) begin
      issued_r <= issued_r + CNT_W'(1);
    end
  end

  // Track the read whose data returns next cycle, along with its index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_r     <= 1'b0;
      inflight_idx_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      inflight_r <= rd_en_s;
      if (rd_en_s) begin
        inflight_idx_r <= issued_r[ADDR_WIDTH-1:0];
      end
    end
  end

  // Completion pulse: high for the cycle after the last beat is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_r <= 1'b0;
    end else begin
      done_r <= finish_s;
    end
  end

  // Two-entry FIFO. head_r always holds the oldest entry, so the stream
  // outputs come straight from a register and stay stable while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r  <= {ENTRY_W{1'b0}};
      tail_r  <= {ENTRY_W{1'b0}};
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= push_entry_s;
          end else begin
            tail_r <= push_entry_s;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_r  <= tail_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_r <= push_entry_s;
          end else begin
            head_r <= tail_r;
            tail_r <= push_entry_s;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign busy      = (state_r == ST_RUN);
  assign done      = done_r;
  assign rd_en     = rd_en_s;
  assign rd_addr   = issued_r[ADDR_WIDTH-1:0];
  assign out_valid = (count_r != 2'd0);
  assign out_a     = head_r[ENTRY_W-1 -: DATA_WIDTH];
  assign out_b     = head_r[ENTRY_W-DATA_WIDTH-1 -: DATA_WIDTH];
  assign out_idx   = head_r[ADDR_WIDTH:1];
  assign out_last  = head_r[0];

  mem_reader_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .count (count_r),
    .busy  (busy),
    .rd_en (rd_en_s)
  );

endmodule

// mem_reader_chk: simulation checks on the reader's internal invariants.
module mem_reader_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       push,
  input logic       pop,
  input logic [1:0] count,
  input logic       busy,
  input logic       rd_en
);

  // A push into a full FIFO without a simultaneous pop would lose data.
  property p_no_overflow;
    @(posedge clk) disable iff (!rst_n) !(push && !pop && (count == 2'd2));
  endproperty
  a_no_overflow: assert property (p_no_overflow) else $error("mem_reader fifo overflow");

  // Reads are only issued while a sequence is running.
  property p_rd_only_busy;
    @(posedge clk) disable iff (!rst_n) rd_en |-> busy;
  endproperty
  a_rd_only_busy: assert property (p_rd_only_busy) else $error("mem_reader read while idle");

endmodule

// File: tb/tb_mem_reader.sv
// tb_mem_reader: scoreboard bench for mem_reader. Stimulus pushes the
// expected beats into a queue. A monitor pops and compares every accepted
// beat, checks hold-stability during stalls and checks the read addresses.
module tb_mem_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, rd_en;
  logic [4:0] rd_addr;
  logic [7:0] mem_dout_a, mem_dout_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a, out_b;
  logic [4:0] out_idx;
  logic       out_last;

  int n_cmp = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int beat_cnt = 0;
  int rdy_mode = 0;
  logic [21:0] sb[$];

  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];

  mem_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .mem_dout_a(mem_dout_a), .mem_dout_b(mem_dout_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_idx(out_idx), .out_last(out_last)
  );

  initial forever #5 clk = ~clk;

  // Memory model: 1-cycle registered read.
  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = 8'(255 - i);
    end
    mem_dout_a = 8'h00;
    mem_dout_b = 8'h00;
    forever begin
      @(posedge clk);
      if (rd_en) begin
        mem_dout_a <= mem_a[rd_addr];
        mem_dout_b <= mem_b[rd_addr];
      end
    end
  end

  // Downstream ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = stalled.
  initial begin
    logic [1:0] ph;
    ph = 2'd0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: begin
          out_ready = (ph == 2'd0) || (ph == 2'd3);
          ph = ph + 2'd1;
        end
        2: out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  function automatic logic [21:0] exp_beat(input int i);
    return {8'(i), 8'(255 - i), 5'(i), (i == 31)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, stall stability, read address sequence.
  initial begin
    logic        hold_pend;
    logic [22:0] held;
    logic [4:0]  rd_exp;
    logic [21:0] e;
    hold_pend = 1'b0;
    held = 23'd0;
    rd_exp = 5'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
        rd_exp = 5'd0;
      end else begin
        if (hold_pend) begin
          n_cmp++;
          if ({out_valid, out_a, out_b, out_idx, out_last} !== held) begin
            n_fail++;
            $display("FAIL stall_hold: got %h expected %h",
                     {out_valid, out_a, out_b, out_idx, out_last}, held);
          end
        end
        if (rd_en) begin
          n_cmp++;
          if ((rd_addr !== rd_exp) || !busy) begin
            n_fail++;
            $display("FAIL rd_addr: got %0d busy %0b expected %0d busy 1", rd_addr, busy, rd_exp);
          end
          rd_exp = rd_exp + 5'd1;
          rd_cnt++;
        end
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: got beat idx %0d expected none", out_idx);
          end else begin
            e = sb.pop_front();
            if ({out_a, out_b, out_idx, out_last} !== e) begin
              n_fail++;
              $display("FAIL beat: got a=%0d b=%0d idx=%0d last=%0b expected a=%0d b=%0d idx=%0d last=%0b",
                       out_a, out_b, out_idx, out_last, e[21:14], e[13:6], e[5:1], e[0]);
            end
          end
          beat_cnt++;
        end
        hold_pend = out_valid && !out_ready;
        held = {out_valid, out_a, out_b, out_idx, out_last};
      end
    end
  end

  task automatic start_seq();
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 32; i++) sb.push_back(exp_beat(i));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
  endtask

  task automatic wait_beats(input int n);
    int i;
    for (i = 0; i < 400 && beat_cnt < n; i++) @(negedge clk);
    chk("beat_wait", (beat_cnt >= n) ? 1 : 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_a"}, out_a, 0);
    chk({tag, "_out_b"}, out_b, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_out_last"}, out_last, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_k, done_k, rd0, d0;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full throughput with exact latency.
    rd0 = rd_cnt;
    d0 = done_cnt;
    start_seq();
    first_k = -1;
    done_k = -1;
    for (int k = 1; k <= 60 && done_k < 0; k++) begin
      @(negedge clk);
      if (out_valid && first_k < 0) first_k = k;
      if (done) done_k = k;
    end
    chk("first_valid_cycle", first_k, 3);
    chk("done_cycle", done_k, 35);
    chk("full_rd_count", rd_cnt - rd0, 32);
    repeat (3) @(negedge clk);
    chk("full_done_count", done_cnt - d0, 1);
    chk("full_busy_after", busy, 0);
    chk("full_sb_empty", sb.size(), 0);

    // Backpressure 1,0,0,1.
    rdy_mode = 1;
    d0 = done_cnt;
    start_seq();
    wait_done(400);
    repeat (2) @(negedge clk);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_done_count", done_cnt - d0, 1);
    rdy_mode = 0;
    repeat (2) @(posedge clk);

    // Long stall.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    rd0 = rd_cnt;
    start_seq();
    repeat (20) @(negedge clk);
    chk("stall_rd_count", rd_cnt - rd0, 2);
    chk("stall_rd_en_low", rd_en, 0);
    chk("stall_out_idx", out_idx, 0);
    rdy_mode = 0;
    wait_done(400);
    repeat (2) @(negedge clk);
    chk("stall_total_rd", rd_cnt - rd0, 32);
    chk("stall_sb_empty", sb.size(), 0);

    // start while busy is ignored.
    d0 = done_cnt;
    beat_cnt = 0;
    start_seq();
    wait_beats(10);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400);
    repeat (5) @(negedge clk);
    chk("busy_start_done_count", done_cnt - d0, 1);
    chk("busy_start_sb_empty", sb.size(), 0);
    chk("busy_start_busy", busy, 0);

    // Reset mid-sequence with reads in flight.
    beat_cnt = 0;
    start_seq();
    wait_beats(15);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("midrst");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_no_push", out_valid, 0);
    d0 = done_cnt;
    start_seq();
    wait_done(400);
    repeat (2) @(negedge clk);
    chk("midrst_sb_empty", sb.size(), 0);
    chk("midrst_done_count", done_cnt - d0, 1);

    // Back-to-back: restart during the done cycle.
    d0 = done_cnt;
    start_seq();
    wait_done(400);
    start = 1'b1;
    for (int i = 0; i < 32; i++) sb.push_back(exp_beat(i));
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy_restart", busy, 1);
    wait_done(400);
    repeat (3) @(negedge clk);
    chk("b2b_done_count", done_cnt - d0, 2);
    chk("b2b_sb_empty", sb.size(), 0);
    chk("b2b_busy_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
